nf_i_fu: RTL and testbench
==========================

NF_I_FU -- requirements
Module: nf_i_fu

Interface
REQ-001 RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 addr_i  out  32  instruction memory word address (bits[1:0] always 0).
REQ-005 req_i  out  1  instruction memory read request.
REQ-006 ack_i  in  1  memory acknowledge; rd_i valid in the ack_i cycle.
REQ-007 rd_i  in  32  instruction memory read data.
REQ-008 instr_if  out  32  fetched instruction word to the decode stage.
REQ-009 pc_if  out  32  address of instr_if.
REQ-010 instr_vld  out  1  instr_if/pc_if valid.
REQ-011 instr_rdy  in  1  decode stage accepts instr_if this cycle.
REQ-012 pc_src  in  1  redirect request from the branch unit.
REQ-013 pc_branch  in  32  redirect target; bits[1:0] ignored, treated as 0.

Function
REQ-014 Internal fetch PC (pc_f) SHALL increment by 4 on each accepted, non-discarded ack.
REQ-015 Output register SHALL be one entry; transfer occurs when instr_vld & instr_rdy.
REQ-016 FSM states SHALL be RUN and KILL.
REQ-017 RUN: req_i SHALL be 1 when the output register is empty or drains this cycle; addr_i = pc_f.
REQ-018 Once req_i=1 without ack_i, req_i and addr_i SHALL hold stable until ack_i (or reset).
REQ-019 RUN, ack_i & !pc_src: instr_if<=rd_i, pc_if<=pc_f, instr_vld<=1, pc_f<=pc_f+4 next edge.
REQ-020 Zero-wait memory (ack_i in the req_i cycle) with instr_rdy=1 SHALL sustain one instruction per cycle.
REQ-021 pc_src=1 in any state SHALL set pc_f<={pc_branch[31:2],2'b00} and clear instr_vld next edge, regardless of instr_rdy.
REQ-022 pc_src with a request outstanding and no ack_i in the same cycle: FSM->KILL; addr_i/req_i held per REQ-018.
REQ-023 KILL: ack_i SHALL discard rd_i, leave pc_f unchanged, and return FSM->RUN; the next req_i uses the redirected pc_f.
REQ-024 pc_src and ack_i in the same cycle: rd_i SHALL be discarded; FSM stays RUN; the next request addresses pc_branch.
REQ-025 A second pc_src in KILL SHALL overwrite pc_f; FSM stays KILL.
REQ-026 pc_f SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without a flag.
REQ-027 No new request SHALL issue while the output register is full and instr_rdy=0; pc_f holds.

Reset
REQ-028 Under reset: pc_f=RESET_PC, FSM=RUN, instr_vld=0, instr_if=0, pc_if=0, req_i=0.
REQ-029 Reset mid-transaction SHALL drop req_i the following cycle, overriding REQ-018; a late ack_i SHALL be ignored until req_i is reasserted.
REQ-030 First req_i SHALL assert in the first cycle after reset deasserts, with addr_i=RESET_PC.

Structure
REQ-031 FSM state enum and the PC increment constant (4) SHALL live in the shared nf_settings package/header.
REQ-032 Single module, no sub-modules; the output register is implemented inline.

Verification
REQ-033 Reset release, zero-wait ack, instr_rdy=1 -> addr_i 0,4,8 on consecutive cycles; instr_vld continuous from cycle 2; pc_if matches.
REQ-034 instr_rdy=0 for 3 cycles with the output register full -> req_i=0 and instr_if/pc_if stable; fetch resumes the cycle instr_rdy=1.
REQ-035 ack delayed 4 cycles on addr 0x8 -> req_i/addr_i stable all 4 cycles; instr_if=rd_i, pc_if=0x8.
REQ-036 pc_src=1, pc_branch=0x103 while addr 0xC is outstanding -> KILL; ack data dropped, instr_vld=0; next addr_i=0x100.
REQ-037 pc_src and ack in the same cycle, pc_branch=0x40 -> data dropped; next addr_i=0x40; following instr_if has pc_if=0x40.
REQ-038 reset asserted during an outstanding request -> req_i=0 next cycle, instr_vld=0; restart at RESET_PC.

Source files
------------

// File: rtl/nf_settings.sv
// Shared settings for the instruction fetch unit: FSM encoding, PC step and
// the word-alignment helper used for redirect targets.
package nf_settings;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/nf_i_fu.sv
// Instruction fetch unit: issues word reads from pc_f, holds one fetched
// instruction for decode, and redirects on branch-unit requests.
module nf_i_fu
  import nf_settings::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr_i,
  output logic        req_i,
  input  logic        ack_i,
  input  logic [31:0] rd_i,
  output logic [31:0] instr_if,
  output logic [31:0] pc_if,
  output logic        instr_vld,
  input  logic        instr_rdy,
  input  logic        pc_src,
  input  logic [31:0] pc_branch
);

  fetch_state_e state_r;
  fetch_state_e state_nxt;
  logic [31:0]  pc_f_r;
  logic [31:0]  pc_f_nxt;
  logic [31:0]  addr_hold_r;
  logic [31:0]  addr_hold_nxt;
  logic         busy_r;
  logic         busy_nxt;
  logic [31:0]  instr_nxt;
  logic [31:0]  pc_if_nxt;
  logic         vld_nxt;
  logic         req_s;
  logic         fire_s;
  logic         take_s;
  logic [31:0]  addr_s;

  // Request and address. busy_r keeps an unanswered request (and its address)
  // stable even across a redirect; reset drops the request immediately.
  always_comb begin
    req_s  = 1'b0;
    addr_s = pc_f_r;
    if (busy_r) begin
      addr_s = addr_hold_r;
    end else begin
      addr_s = pc_f_r;
    end
    if (reset) begin
      req_s = 1'b0;
    end else if (busy_r) begin
      req_s = 1'b1;
    end else if ((state_r == ST_RUN) && (!instr_vld || instr_rdy)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  assign fire_s = req_s & ack_i;
  // Only a RUN-state ack without a simultaneous redirect delivers data.
  assign take_s = fire_s & (state_r == ST_RUN) & ~pc_src;
  assign req_i  = req_s;
  assign addr_i = addr_s;

  // Next-state and next-register values; defaults hold everything.
  always_comb begin
    state_nxt     = state_r;
    pc_f_nxt      = pc_f_r;
    addr_hold_nxt = addr_hold_r;
    busy_nxt      = busy_r;
    instr_nxt     = instr_if;
    pc_if_nxt     = pc_if;
    vld_nxt       = instr_vld;

    case (state_r)
      ST_RUN: begin
        if (pc_src && req_s && !ack_i) begin
          state_nxt = ST_KILL;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_KILL: begin
        if (ack_i) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_KILL;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    if (fire_s) begin
      busy_nxt = 1'b0;
    end else if (req_s) begin
      busy_nxt      = 1'b1;
      addr_hold_nxt = addr_s;
    end else begin
      busy_nxt = busy_r;
    end

    if (take_s) begin
      instr_nxt = rd_i;
      pc_if_nxt = pc_f_r;
    end else begin
      instr_nxt = instr_if;
      pc_if_nxt = pc_if;
    end

    if (pc_src) begin
      vld_nxt = 1'b0;
    end else if (take_s) begin
      vld_nxt = 1'b1;
    end else if (instr_vld && instr_rdy) begin
      vld_nxt = 1'b0;
    end else begin
      vld_nxt = instr_vld;
    end

    if (pc_src) begin
      pc_f_nxt = word_align(pc_branch);
    end else if (take_s) begin
      pc_f_nxt = pc_f_r + PC_INC;
    end else begin
      pc_f_nxt = pc_f_r;
    end
  end

  // State, PC and output-register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      pc_f_r      <= RESET_PC;
      addr_hold_r <= RESET_PC;
      busy_r      <= 1'b0;
      instr_if    <= 32'h0000_0000;
      pc_if       <= 32'h0000_0000;
      instr_vld   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      pc_f_r      <= pc_f_nxt;
      addr_hold_r <= addr_hold_nxt;
      busy_r      <= busy_nxt;
      instr_if    <= instr_nxt;
      pc_if       <= pc_if_nxt;
      instr_vld   <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_nf_i_fu.sv
// Self-checking bench for nf_i_fu: directed scenarios plus randomized traffic
// against a transaction-level fetch model and a variable-latency memory.
module tb_nf_i_fu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_i;
  logic        req_i;
  logic        ack_i;
  logic [31:0] rd_i;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic        instr_vld;
  logic        instr_rdy;
  logic        pc_src;
  logic [31:0] pc_branch;

  int checks = 0;
  int errors = 0;

  // Model: next fetch address, in-flight request, drop flag, decode slot.
  logic [31:0] m_pc, m_busy_addr, m_instr, m_pcif;
  bit          m_busy, m_drop, m_vld, m_init;
  // Memory side.
  bit          mem_busy;
  int          mem_cnt;
  // Last sampled DUT outputs for directed checks.
  logic [31:0] s_addr, s_instr, s_pcif;
  logic        s_req, s_vld;

  always #5 clk = ~clk;

  nf_i_fu dut (
    .clk       (clk),
    .reset     (reset),
    .addr_i    (addr_i),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .rd_i      (rd_i),
    .instr_if  (instr_if),
    .pc_if     (pc_if),
    .instr_vld (instr_vld),
    .instr_rdy (instr_rdy),
    .pc_src    (pc_src),
    .pc_branch (pc_branch)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, answer as memory, compare, advance model.
  // wt >= 0 fixes the latency of a newly issued request, wt < 0 randomizes it.
  task automatic step(input logic rst, input logic rdy, input logic src,
                      input logic [31:0] br, input int wt);
    logic        ack_v;
    logic [31:0] rd_v;
    logic        exp_req;
    logic [31:0] e_addr;
    logic        fired, taken;
    @(negedge clk);
    reset     = rst;
    instr_rdy = rdy;
    pc_src    = src;
    pc_branch = br;
    #1;
    ack_v = 1'b0;
    rd_v  = $urandom;
    if (rst) begin
      mem_busy = 1'b0;
      ack_v    = 1'($urandom_range(0, 1));
    end else if (req_i === 1'b1) begin
      if (!mem_busy) begin
        if (wt >= 0) mem_cnt = wt;
        else mem_cnt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      end
      if (mem_cnt == 0) begin
        ack_v    = 1'b1;
        rd_v     = mem_word(addr_i);
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
        mem_busy = 1'b1;
      end
    end else begin
      ack_v = ($urandom_range(0, 9) == 0);
    end
    ack_i = ack_v;
    rd_i  = rd_v;
    #1;
    s_req = req_i; s_addr = addr_i; s_vld = instr_vld; s_instr = instr_if; s_pcif = pc_if;

    exp_req = 1'b0;
    e_addr  = m_busy ? m_busy_addr : m_pc;
    if (m_init) begin
      exp_req = !rst && (m_busy || !m_vld || rdy);
      check("req_i", {31'd0, req_i}, {31'd0, exp_req});
      if (exp_req) check("addr_i", addr_i, e_addr);
      check("instr_vld", {31'd0, instr_vld}, {31'd0, m_vld});
      check("instr_if", instr_if, m_instr);
      check("pc_if", pc_if, m_pcif);
    end

    if (rst) begin
      m_pc = 32'h0; m_busy = 0; m_drop = 0; m_vld = 0;
      m_instr = 32'h0; m_pcif = 32'h0; m_init = 1;
    end else if (m_init) begin
      fired = exp_req && ack_v;
      taken = fired && !m_drop && !src;
      if (src) m_vld = 0;
      else if (taken) m_vld = 1;
      else if (m_vld && rdy) m_vld = 0;
      if (taken) begin
        m_instr = rd_v;
        m_pcif  = e_addr;
        m_pc    = m_pc + 32'd4;
      end
      if (src) m_pc = {br[31:2], 2'b00};
      if (fired) begin
        m_busy = 0;
        m_drop = 0;
      end else if (exp_req) begin
        m_busy      = 1;
        m_busy_addr = e_addr;
        if (src) m_drop = 1;
      end
    end
  endtask

  initial begin
    logic        r_rst, r_rdy, r_src;
    logic [31:0] r_br;
    reset = 1'b1; instr_rdy = 1'b0; pc_src = 1'b0; pc_branch = 32'h0;
    ack_i = 1'b0; rd_i = 32'h0;
    m_init = 0; mem_busy = 0; mem_cnt = 0;

    // Reset state.
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("rst_req", {31'd0, s_req}, 32'd0);
    check("rst_vld", {31'd0, s_vld}, 32'd0);
    check("rst_instr", s_instr, 32'h0);
    check("rst_pcif", s_pcif, 32'h0);

    // Zero-wait streaming: 0,4,8 back to back.
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("c1_req", {31'd0, s_req}, 32'd1);
    check("c1_addr", s_addr, 32'h0);
    check("c1_vld", {31'd0, s_vld}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("c2_addr", s_addr, 32'h4);
    check("c2_vld", {31'd0, s_vld}, 32'd1);
    check("c2_pcif", s_pcif, 32'h0);
    check("c2_instr", s_instr, mem_word(32'h0));
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("c3_addr", s_addr, 32'h8);
    check("c3_pcif", s_pcif, 32'h4);

    // Back-pressure: full slot with instr_rdy=0 stalls fetching.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 0);
      check("stall_req", {31'd0, s_req}, 32'd0);
      check("stall_pcif", s_pcif, 32'h8);
      check("stall_instr", s_instr, mem_word(32'h8));
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("resume_req", {31'd0, s_req}, 32'd1);
    check("resume_addr", s_addr, 32'hC);

    // Delayed ack on 0x8: request held for the whole wait.
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 4);
    check("wait_addr0", s_addr, 32'h8);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 0);
      check("wait_req", {31'd0, s_req}, 32'd1);
      check("wait_addr", s_addr, 32'h8);
    end

    // Redirect while 0xC is outstanding.
    step(1'b0, 1'b1, 1'b0, 32'h0, 3);
    check("late_pcif", s_pcif, 32'h8);
    check("late_instr", s_instr, mem_word(32'h8));
    check("kill_addr0", s_addr, 32'hC);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("kill_vld", {31'd0, s_vld}, 32'd0);
    check("kill_addr1", s_addr, 32'hC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("kill_addr2", s_addr, 32'hC);

    // Redirect colliding with an ack.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0040, 0);
    check("redir_addr", s_addr, 32'h100);
    check("redir_vld", {31'd0, s_vld}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("coll_addr", s_addr, 32'h40);
    check("coll_vld", {31'd0, s_vld}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("coll_pcif", s_pcif, 32'h40);
    check("coll_instr", s_instr, mem_word(32'h40));

    // Reset during an outstanding request.
    step(1'b0, 1'b1, 1'b0, 32'h0, 3);
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("mid_rst_req", {31'd0, s_req}, 32'd0);
    check("mid_rst_vld", {31'd0, s_vld}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("restart_req", {31'd0, s_req}, 32'd1);
    check("restart_addr", s_addr, 32'h0);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB, 0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("wrap_addr0", s_addr, 32'hFFFF_FFF8);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("wrap_addr1", s_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    check("wrap_addr2", s_addr, 32'h0);
    check("wrap_pcif", s_pcif, 32'hFFFF_FFFC);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_src = !r_rst && ($urandom_range(0, 19) == 0);
      r_br  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      step(r_rst, r_rdy, r_src, r_br, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
